// File: rtl/ram_port_arbiter_pkg.sv
// Shared encodings for the RAM port-B arbiter: FSM states, access owners
// and the fixed-priority-with-starvation-override winner selection.
package ram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_AUX = 1'b1
  } owner_e;

  // CPU wins ties; a starved AUX overrides that.
  function automatic owner_e pick_winner(input logic cpu_req,
                                         input logic aux_req,
                                         input logic starved);
    return (aux_req && (!cpu_req || starved)) ? OWN_AUX : OWN_CPU;
  endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive arbitrations lost by AUX; flags
// starvation once the count reaches MAX_WAIT.
module arb_starve_counter #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic starved
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CW'(MAX_WAIT))) begin
      count <= count + 1'b1;
    end
  end

  assign starved = (count == CW'(MAX_WAIT));

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates RAM port B between the CPU load/store FSM and an AUX reader,
// issuing one registered access at a time and returning read data with rvalid.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_gnt,
  output logic              aux_rvalid,
  output logic [DATA_W-1:0] aux_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  owner_e              winner;
  logic                starved, cnt_clr, cnt_inc;
  logic                ram_en_d, ram_we_d, busy_d;
  logic [ADDR_W-1:0]   ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_d, cpu_rdata_d, aux_rdata_d;
  logic                cpu_gnt_d, aux_gnt_d, cpu_rvalid_d, aux_rvalid_d;

  arb_starve_counter #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve (
    .clk    (clk),
    .reset  (reset),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .starved(starved)
  );

  always_comb begin
    // NOTE: every combinational output is defaulted first so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d      = state_q;
    owner_d      = owner_q;
    ram_en_d     = 1'b0;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr;
    ram_wdata_d  = ram_wdata;
    cpu_gnt_d    = 1'b0;
    aux_gnt_d    = 1'b0;
    cpu_rvalid_d = 1'b0;
    aux_rvalid_d = 1'b0;
    cpu_rdata_d  = cpu_rdata;
    aux_rdata_d  = aux_rdata;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    winner       = pick_winner(cpu_req, aux_req, starved);

    case (state_q)
      ST_IDLE: begin
        cnt_clr = !aux_req || (winner == OWN_AUX);
        cnt_inc = aux_req && (winner == OWN_CPU);
        if (cpu_req || aux_req) begin
          // The port-B output registers double as the access latch.
          state_d     = ST_ISSUE;
          owner_d     = winner;
          ram_en_d    = 1'b1;
          ram_we_d    = (winner == OWN_AUX) ? aux_we    : cpu_we;
          ram_addr_d  = (winner == OWN_AUX) ? aux_addr  : cpu_addr;
          ram_wdata_d = (winner == OWN_AUX) ? aux_wdata : cpu_wdata;
          cpu_gnt_d   = (winner == OWN_CPU);
          aux_gnt_d   = (winner == OWN_AUX);
        end
      end
      ST_ISSUE: begin
        state_d = ram_we ? ST_IDLE : ST_WAIT_RD;
      end
      ST_WAIT_RD: begin
        state_d = ST_IDLE;
        if (owner_q == OWN_AUX) begin
          aux_rvalid_d = 1'b1;
          aux_rdata_d  = ram_rdata;
        end else begin
          cpu_rvalid_d = 1'b1;
          cpu_rdata_d  = ram_rdata;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_CPU;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      cpu_gnt    <= 1'b0;
      aux_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      aux_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      aux_rdata  <= '0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ram_en     <= ram_en_d;
      ram_we     <= ram_we_d;
      ram_addr   <= ram_addr_d;
      ram_wdata  <= ram_wdata_d;
      cpu_gnt    <= cpu_gnt_d;
      aux_gnt    <= aux_gnt_d;
      cpu_rvalid <= cpu_rvalid_d;
      aux_rvalid <= aux_rvalid_d;
      cpu_rdata  <= cpu_rdata_d;
      aux_rdata  <= aux_rdata_d;
      busy       <= busy_d;
    end
  end

endmodule
